// File: rtl/sdr_fec_pkg.sv
// Shared FEC types and constants: encoder state enum, BCH generator polynomials, counter width helper.
// Pure declarations, no logic.
package sdr_fec_pkg;

  typedef enum logic {
    MSG    = 1'b0,
    PARITY = 1'b1
  } enc_state_t;

  // Octal 12471: x^12+x^10+x^8+x^5+x^4+x^3+1
  localparam logic [12:0] BCH_63_51_POLY = 13'h1539;
  // Octal 1701317, t=3 code
  localparam logic [18:0] BCH_63_45_POLY = 19'h782CF;

  function automatic int cnt_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bch_lfsr_div.sv
// Remainder register of a Galois-style LFSR divider by g(x); msb is rem[M-1] combinationally.
// Single cycle per shift; the caller decides when to shift, so no flow control of its own.
module bch_lfsr_div #(
  parameter int M = 12,
  parameter logic [M:0] GEN_POLY = 13'h1539
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic shift_in_en,
  input  logic shift_out_en,
  input  logic din,
  output logic msb
);

  logic [M-1:0] rem;
  logic         fb;

  assign fb  = din ^ rem[M-1];
  assign msb = rem[M-1];

  // clr wins so a frame can end on the same beat as its last shift
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem <= '0;
    end else if (clr) begin
      rem <= '0;
    end else if (shift_in_en) begin
      rem <= (rem << 1) ^ (fb ? GEN_POLY[M-1:0] : '0);
    end else if (shift_out_en) begin
      rem <= rem << 1;
    end
  end

endmodule

// File: rtl/bch_encoder_param.sv
// Bit-serial systematic BCH encoder: K message bits pass through, then N-K LFSR parity bits (or none in bypass).
// One-cycle registered output; holds while valid_out && !ready_out, ready_in only when the slot frees in MSG.
module bch_encoder_param
  import sdr_fec_pkg::*;
#(
  parameter int N = 63,
  parameter int K = 51,
  parameter logic [N-K:0] GEN_POLY = BCH_63_51_POLY
) (
  input  logic clk,
  input  logic rst,
  input  logic valid_in,
  output logic ready_in,
  input  logic data_in,
  input  logic bypass_in,
  output logic valid_out,
  input  logic ready_out,
  output logic data_out,
  output logic last_out
);

  localparam int M  = N - K;
  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] CNT_LAST_MSG  = CW'(K - 1);
  localparam logic [CW-1:0] CNT_FIRST_PAR = CW'(K);
  localparam logic [CW-1:0] CNT_LAST      = CW'(N - 1);

  if (GEN_POLY[M] != 1'b1 || GEN_POLY[0] != 1'b1 || N <= K) begin : g_bad_param
    $error("bch_encoder_param: invalid N/K/GEN_POLY");
  end

  enc_state_t    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          bypass_q, bypass_nxt;
  logic          valid_nxt, data_nxt, last_nxt;
  logic          slot_free, byp_now, accept;
  logic          lfsr_clr, shift_in_en, shift_out_en, rem_msb;

  assign slot_free = !valid_out || ready_out;
  assign ready_in  = (state == MSG) && slot_free;
  assign accept    = valid_in && ready_in;
  // A K==1 frame ends on its first bit, before bypass_q has captured the flag
  assign byp_now   = (cnt == '0) ? bypass_in : bypass_q;

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    bypass_nxt   = bypass_q;
    valid_nxt    = valid_out;
    data_nxt     = data_out;
    last_nxt     = last_out;
    lfsr_clr     = 1'b0;
    shift_in_en  = 1'b0;
    shift_out_en = 1'b0;
    if (slot_free) begin
      valid_nxt = 1'b0;
      last_nxt  = 1'b0;
      case (state)
        MSG: begin
          if (accept) begin
            valid_nxt   = 1'b1;
            data_nxt    = data_in;
            shift_in_en = 1'b1;
            cnt_nxt     = cnt + CW'(1);
            if (cnt == '0) bypass_nxt = bypass_in;
            if (cnt == CNT_LAST_MSG) begin
              if (byp_now) begin
                last_nxt = 1'b1;
                cnt_nxt  = '0;
                lfsr_clr = 1'b1;
              end else begin
                state_nxt = PARITY;
                cnt_nxt   = CNT_FIRST_PAR;
              end
            end
          end
        end
        PARITY: begin
          valid_nxt    = 1'b1;
          data_nxt     = rem_msb;
          shift_out_en = 1'b1;
          cnt_nxt      = cnt + CW'(1);
          if (cnt == CNT_LAST) begin
            last_nxt  = 1'b1;
            cnt_nxt   = '0;
            lfsr_clr  = 1'b1;
            state_nxt = MSG;
          end
        end
        default: state_nxt = MSG;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= MSG;
      cnt       <= '0;
      bypass_q  <= 1'b0;
      valid_out <= 1'b0;
      data_out  <= 1'b0;
      last_out  <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      bypass_q  <= bypass_nxt;
      valid_out <= valid_nxt;
      data_out  <= data_nxt;
      last_out  <= last_nxt;
    end
  end

  bch_lfsr_div #(
    .M        (M),
    .GEN_POLY (GEN_POLY[M:0])
  ) u_lfsr (
    .clk          (clk),
    .rst          (rst),
    .clr          (lfsr_clr),
    .shift_in_en  (shift_in_en),
    .shift_out_en (shift_out_en),
    .din          (data_in),
    .msb          (rem_msb)
  );

endmodule

// File: tb/tb_bch_encoder_param.sv
// Directed bench for bch_encoder_param (63,51): streams compared beat by beat against a long-division model.
module tb_bch_encoder_param;

  localparam int N = 63;
  localparam int K = 51;
  localparam int M = N - K;
  localparam logic [M:0] G = 13'h1539;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic valid_in = 1'b0;
  logic data_in = 1'b0;
  logic bypass_in = 1'b0;
  logic ready_out = 1'b1;
  logic rnd_ready = 1'b0;
  logic ready_in, valid_out, data_out, last_out;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [1:0] out_q[$];
  int         out_cyc[$];
  logic [1:0] exp_q[$];

  bch_encoder_param #(.N(N), .K(K), .GEN_POLY(G)) dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .ready_in  (ready_in),
    .data_in   (data_in),
    .bypass_in (bypass_in),
    .valid_out (valid_out),
    .ready_out (ready_out),
    .data_out  (data_out),
    .last_out  (last_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Downstream ready: 30% random low when enabled
  always @(posedge clk) begin
    #1;
    ready_out = rnd_ready ? ($urandom_range(0, 99) >= 30) : 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output monitor: collects transferred beats and checks stall stability
  logic prev_stall = 1'b0;
  logic prev_d = 1'b0;
  logic prev_l = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        check("stall_hold", 32'({valid_out, data_out, last_out}), 32'({1'b1, prev_d, prev_l}));
      if (valid_out && ready_out) begin
        out_q.push_back({last_out, data_out});
        out_cyc.push_back(cyc);
      end
      prev_stall = valid_out && !ready_out;
      prev_d     = data_out;
      prev_l     = last_out;
    end
  end

  // Reference codeword by polynomial long division; m[0] is the first transmitted bit
  function automatic void expect_frame(input logic [K-1:0] m, input logic byp);
    logic c[N];
    for (int i = 0; i < N; i++) c[i] = (i < K) ? m[i] : 1'b0;
    for (int i = 0; i < K; i++)
      if (c[i])
        for (int j = 0; j <= M; j++) c[i+j] = c[i+j] ^ G[M-j];
    for (int i = 0; i < K; i++) exp_q.push_back({byp && (i == K - 1), m[i]});
    if (!byp)
      for (int i = K; i < N; i++) exp_q.push_back({i == N - 1, c[i]});
  endfunction

  task automatic send_bit(input logic b, input logic byp, output int waited);
    waited = 0;
    valid_in = 1'b1;
    data_in = b;
    bypass_in = byp;
    @(negedge clk);
    while (!ready_in && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    if (!ready_in) check("ready_in_timeout", 32'(ready_in), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [K-1:0] m, input logic byp_first, input logic byp_rest,
                            output int w_first, output int w_rest);
    int w;
    w_rest = 0;
    w_first = 0;
    for (int i = 0; i < K; i++) begin
      send_bit(m[i], (i == 0) ? byp_first : byp_rest, w);
      if (i == 0) w_first = w;
      else w_rest += w;
    end
  endtask

  task automatic drain();
    int t = 0;
    valid_in = 1'b0;
    bypass_in = 1'b0;
    while (out_q.size() < exp_q.size() && t < 4000) begin
      @(negedge clk);
      t++;
    end
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic compare_stream(input string name);
    check({name, "_nbeats"}, 32'(out_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < out_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s_beat%0d", name, i), 32'(out_q[i]), 32'(exp_q[i]));
  endtask

  task automatic check_gapless(input string name);
    if (out_cyc.size() > 0)
      check({name, "_gapless"}, 32'(out_cyc[out_cyc.size()-1] - out_cyc[0]), 32'(out_cyc.size() - 1));
    else
      check({name, "_no_output"}, 32'(out_cyc.size()), 32'd1);
  endtask

  task automatic clear_q();
    out_q.delete();
    out_cyc.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [K-1:0] m;
    logic [M-1:0] par;
    int w, wf, wr;
    int wf2, wr2, wf3, wr3;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid_out", 32'(valid_out), 32'd0);
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_last_out", 32'(last_out), 32'd0);
    check("rst_ready_in", 32'(ready_in), 32'd1);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;

    // All-zero message: 63 zero beats, last on beat 62, one-cycle latency
    clear_q();
    m = '0;
    expect_frame(m, 1'b0);
    send_bit(1'b0, 1'b0, w);
    check("zero_latency_vld", 32'(valid_out), 32'd1);
    wr = 0;
    for (int i = 1; i < K; i++) begin
      send_bit(1'b0, 1'b0, w);
      wr += w;
    end
    check("zero_msg_waits", 32'(wr), 32'd0);
    drain();
    compare_stream("zero");
    check_gapless("zero");

    // Only the last message bit set: parity must be g(x) - x^12 = 0x539
    clear_q();
    m = '0;
    m[K-1] = 1'b1;
    expect_frame(m, 1'b0);
    send_frame(m, 1'b0, 1'b0, wf, wr);
    drain();
    compare_stream("unit");
    par = '0;
    if (out_q.size() == N)
      for (int i = K; i < N; i++) par = {par[M-2:0], out_q[i][0]};
    check("unit_parity", 32'(par), 32'h539);
    if (out_q.size() == N) check("unit_last62", 32'(out_q[N-1][1]), 32'd1);

    // Random messages under random backpressure
    clear_q();
    rnd_ready = 1'b1;
    for (int f = 0; f < 3; f++) begin
      m = K'({$urandom(), $urandom()});
      expect_frame(m, 1'b0);
      send_frame(m, 1'b0, 1'b0, wf, wr);
      if (f > 0) check($sformatf("rnd_parity_block%0d", f), 32'(wf >= 12), 32'd1);
    end
    drain();
    rnd_ready = 1'b0;
    drain();
    compare_stream("rnd");

    // Three back-to-back frames, valid_in held high
    clear_q();
    m = K'({$urandom(), $urandom()});
    expect_frame(m, 1'b0);
    send_frame(m, 1'b0, 1'b0, wf, wr);
    m = K'({$urandom(), $urandom()});
    expect_frame(m, 1'b0);
    send_frame(m, 1'b0, 1'b0, wf2, wr2);
    m = K'({$urandom(), $urandom()});
    expect_frame(m, 1'b0);
    send_frame(m, 1'b0, 1'b0, wf3, wr3);
    drain();
    check("b2b_wait_f1", 32'(wf), 32'd0);
    check("b2b_wait_f2", 32'(wf2), 32'd12);
    check("b2b_wait_f3", 32'(wf3), 32'd12);
    check("b2b_msg_waits", 32'(wr + wr2 + wr3), 32'd0);
    compare_stream("b2b");
    check_gapless("b2b");

    // Bypass on frame 2 only; bypass_in on non-first bits of frame 1 must be ignored
    clear_q();
    m = K'({$urandom(), $urandom()});
    expect_frame(m, 1'b0);
    send_frame(m, 1'b0, 1'b1, wf, wr);
    m = K'({$urandom(), $urandom()});
    m[K-1] = 1'b1;
    expect_frame(m, 1'b1);
    send_frame(m, 1'b1, 1'b0, wf2, wr2);
    m = K'({$urandom(), $urandom()});
    expect_frame(m, 1'b0);
    send_frame(m, 1'b0, 1'b0, wf3, wr3);
    drain();
    check("byp_wait_f2", 32'(wf2), 32'd12);
    check("byp_wait_f3", 32'(wf3), 32'd0);
    compare_stream("byp");
    check_gapless("byp");

    // Asynchronous reset at message bit 20, then a clean frame
    clear_q();
    m = K'({$urandom(), $urandom()});
    m[19] = 1'b1;
    for (int i = 0; i < 20; i++) send_bit(m[i], 1'b0, w);
    check("pre_rst_data", 32'({valid_out, data_out}), 32'b11);
    valid_in = 1'b0;
    rst = 1'b0;
    #1;
    check("arst_valid_out", 32'(valid_out), 32'd0);
    check("arst_data_out", 32'(data_out), 32'd0);
    check("arst_last_out", 32'(last_out), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    clear_q();
    m = K'({$urandom(), $urandom()});
    m[0] = 1'b1;
    expect_frame(m, 1'b0);
    send_bit(m[0], 1'b0, w);
    check("post_rst_latency", 32'({valid_out, data_out}), 32'b11);
    for (int i = 1; i < K; i++) send_bit(m[i], 1'b0, w);
    drain();
    compare_stream("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
